// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
// The memory read is combinational: rdata follows raddr within the same cycle.
interface instr_fetch_stage_if;
  logic [31:0] imem_raddr_o;
  logic        imem_ren_o;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_raddr_o,
    output imem_ren_o,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_raddr_o,
    input  imem_ren_o,
    output imem_rdata_i
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// PC register and IF/ID pipeline register for the MIPS core.
// Handles stall, flush, redirect, and a sticky fault on illegal or out-of-range fetch addresses.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic                        redirect_i,
  input  logic [31:0]                 redirect_pc_i,
  instr_fetch_stage_if.master         imem,
  output logic                        if_id_valid_o,
  output logic [31:0]                 if_id_instr_o,
  output logic [31:0]                 if_id_pc_o,
  output logic [31:0]                 if_id_pc4_o,
  output logic                        fetch_fault_o
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        fault_q, fault_d;

  function automatic logic in_range(input logic [31:0] addr);
    return {2'b00, addr[31:2]} < IMEM_DEPTH;
  endfunction

  function automatic logic legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && in_range(addr);
  endfunction

  logic [31:0] pc_plus4;
  logic        pc_ok;
  logic        redirect_ok;

  assign pc_plus4    = pc_q + 32'd4;
  assign pc_ok       = in_range(pc_q);
  assign redirect_ok = legal(redirect_pc_i);

  assign imem.imem_raddr_o = {2'b00, pc_q[31:2]};
  assign imem.imem_ren_o   = (state_q == StRun) && !stall_i && pc_ok;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    fault_d  = fault_q;

    unique case (state_q)
      StBoot: begin
        valid_d = 1'b0;
        if (legal(RESET_PC)) begin
          state_d = StRun;
        end else begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end

      StRun: begin
        if (redirect_i) begin
          // Target is loaded even when illegal so raddr shows the faulting address.
          pc_d    = redirect_pc_i;
          valid_d = 1'b0;
          if (!redirect_ok) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end
        end else if (stall_i) begin
          if (flush_i) valid_d = 1'b0;
        end else if (!pc_ok) begin
          fault_d = 1'b1;
          valid_d = 1'b0;
          state_d = StHalt;
        end else begin
          instr_d  = imem.imem_rdata_i;
          id_pc_d  = pc_q;
          id_pc4_d = pc_plus4;
          valid_d  = !flush_i;
          pc_d     = pc_plus4;
        end
      end

      StHalt: begin
        valid_d = 1'b0;
        if (redirect_i && redirect_ok) begin
          pc_d    = redirect_pc_i;
          fault_d = 1'b0;
          state_d = StRun;
        end
      end

      default: begin
        state_d = StHalt;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      id_pc_q  <= 32'h0;
      id_pc4_q <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      fault_q  <= fault_d;
    end
  end

  assign if_id_valid_o = valid_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;
  assign fetch_fault_o = fault_q;

endmodule
